// File: rtl/gba_save_flush_if.sv
// Signal bundle for the save flusher: game save events, host byte port,
// backing-memory port and the outgoing byte stream.
interface gba_save_flush_if;
  logic        model;
  logic        eeprom_written;
  logic [9:0]  eeprom_blk;
  logic        flush_req;
  logic        rv_rd;
  logic        rv_wr;
  logic [12:0] rv_addr;
  logic [7:0]  rv_wdata;
  logic [7:0]  rv_rdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [9:0]  out_blk;
  logic        out_last;
  logic        busy;
  logic        dirty_any;
  logic        flush_done;

  modport master (
    output model, eeprom_written, eeprom_blk, flush_req,
    output rv_rd, rv_wr, rv_addr, rv_wdata, mem_rdata, out_ready,
    input  rv_rdata, mem_rd, mem_wr, mem_addr, mem_wdata,
    input  out_valid, out_data, out_blk, out_last, busy, dirty_any, flush_done
  );

  modport slave (
    input  model, eeprom_written, eeprom_blk, flush_req,
    input  rv_rd, rv_wr, rv_addr, rv_wdata, mem_rdata, out_ready,
    output rv_rdata, mem_rd, mem_wr, mem_addr, mem_wdata,
    output out_valid, out_data, out_blk, out_last, busy, dirty_any, flush_done
  );
endinterface

// File: rtl/gba_save_flush.sv
// EEPROM save write-back scheduler: tracks dirty 64-bit blocks, waits for a
// quiet period after the last game write, then streams every dirty block out
// byte by byte while sharing the backing-memory port with the host.
//
// state | meaning
// IDLE  | waiting for quiet period or flush request
// SCAN  | testing dirty bit of block blk, one block per cycle
// ISSUE | reading byte {blk,byte} from backing memory when host is idle
// WAIT  | capturing backing-memory read data
// SEND  | presenting the byte on the stream until accepted
// DONE  | one-cycle completion pulse, quiet timer restarted
module gba_save_flush #(
  parameter int unsigned QUIET_CYCLES = 1_000_000
) (
  input logic             clk,
  input logic             rst,
  gba_save_flush_if.slave bus
);
  localparam logic [31:0] QUIET_MAX = 32'(QUIET_CYCLES);

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, SEND, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1023:0] dirty;
  logic [1023:0] dirty_nxt;
  logic          dirty_any_q;
  logic [31:0]   quiet_cnt;
  logic [9:0]    blk;
  logic [9:0]    last_blk;
  logic [2:0]    byte_idx;
  logic [7:0]    out_data_q;
  logic [9:0]    wr_blk;
  logic          host_act;
  logic          start_scan;
  logic          scan_clr;
  logic          blk_inc;
  logic          byte_inc;
  logic          eng_rd;
  logic          capture;

  assign host_act = bus.rv_rd | bus.rv_wr;
  assign wr_blk   = bus.model ? bus.eeprom_blk : {4'b0000, bus.eeprom_blk[5:0]};

  // Host always owns the port when it strobes; otherwise the engine reads.
  always_comb begin
    bus.mem_rd    = host_act ? bus.rv_rd : eng_rd;
    bus.mem_wr    = host_act & bus.rv_wr;
    bus.mem_addr  = host_act ? bus.rv_addr : {blk, byte_idx};
    bus.mem_wdata = bus.rv_wdata;
    bus.rv_rdata  = bus.mem_rdata;
  end

  // Next bitmap: scan clears the examined bit, a game write sets (and wins).
  always_comb begin
    dirty_nxt = dirty;
    if (scan_clr) dirty_nxt[blk] = 1'b0;
    if (bus.eeprom_written) dirty_nxt[wr_blk] = 1'b1;
  end

  // FSM next-state and per-state control strobes.
  always_comb begin
    state_nxt  = state;
    start_scan = 1'b0;
    scan_clr   = 1'b0;
    blk_inc    = 1'b0;
    byte_inc   = 1'b0;
    eng_rd     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (dirty_any_q && (quiet_cnt == QUIET_MAX || bus.flush_req)) begin
          start_scan = 1'b1;
          state_nxt  = SCAN;
        end
      end
      SCAN: begin
        if (dirty[blk]) begin
          scan_clr  = 1'b1;
          state_nxt = ISSUE;
        end else if (blk == last_blk) begin
          state_nxt = DONE;
        end else begin
          blk_inc = 1'b1;
        end
      end
      ISSUE: begin
        if (!host_act) begin
          eng_rd    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        capture   = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (bus.out_ready) begin
          if (byte_idx == 3'd7) begin
            if (blk == last_blk) begin
              state_nxt = DONE;
            end else begin
              blk_inc   = 1'b1;
              state_nxt = SCAN;
            end
          end else begin
            byte_inc  = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Dirty bitmap and its registered OR summary.
  always_ff @(posedge clk) begin
    if (rst) begin
      dirty       <= '0;
      dirty_any_q <= 1'b0;
    end else begin
      dirty       <= dirty_nxt;
      dirty_any_q <= |dirty_nxt;
    end
  end

  // Scan pointer, byte index, block limit and captured stream byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk        <= '0;
      last_blk   <= '0;
      byte_idx   <= '0;
      out_data_q <= '0;
    end else begin
      if (start_scan) begin
        blk      <= '0;
        last_blk <= bus.model ? 10'd1023 : 10'd63;
      end else if (blk_inc) begin
        blk <= blk + 10'd1;
      end
      if (scan_clr)      byte_idx <= '0;
      else if (byte_inc) byte_idx <= byte_idx + 3'd1;
      if (capture) out_data_q <= bus.mem_rdata;
    end
  end

  // Quiet timer: restarts on every game write and after each flush.
  always_ff @(posedge clk) begin
    if (rst)                                         quiet_cnt <= '0;
    else if (bus.eeprom_written || state == DONE)    quiet_cnt <= '0;
    else if (state == IDLE && quiet_cnt != QUIET_MAX) quiet_cnt <= quiet_cnt + 32'd1;
  end

  // Status and stream outputs decoded from state.
  always_comb begin
    bus.out_valid  = (state == SEND);
    bus.out_last   = (state == SEND) && (byte_idx == 3'd7);
    bus.out_data   = out_data_q;
    bus.out_blk    = blk;
    bus.busy       = (state != IDLE);
    bus.dirty_any  = dirty_any_q;
    bus.flush_done = (state == DONE);
  end
endmodule

// File: tb/tb_gba_save_flush.sv
// Self-checking bench for gba_save_flush: table-driven host port vectors,
// scoreboarded output stream, and hand-written flush corner sequences.
module tb_gba_save_flush;
  localparam int Q = 16;
  localparam int BLKS [4] = '{5, 2, 7, 63};

  logic clk = 1'b0;
  logic rst;

  gba_save_flush_if bus_if();

  gba_save_flush #(.QUIET_CYCLES(Q)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Backing memory: one-cycle read latency.
  logic [7:0] mem [0:8191];
  always @(posedge clk) begin
    if (bus_if.mem_wr) mem[bus_if.mem_addr] <= bus_if.mem_wdata;
    if (bus_if.mem_rd) bus_if.mem_rdata <= mem[bus_if.mem_addr];
  end

  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;

  typedef struct packed {
    logic [9:0] blk;
    logic [7:0] data;
    logic       last;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } hvec_t;
  hvec_t hv [40];

  function automatic logic [7:0] pat(input int b, input int i);
    if (b == 5) return 8'(8'hA0 + i);
    return 8'(b * 16 + i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_blk(input int b);
    for (int i = 0; i < 8; i++)
      sb.push_back('{blk: 10'(b), data: pat(b, i), last: (i == 7)});
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!bus_if.out_valid && n < budget) begin
      cyc();
      n++;
    end
    chk(name, 32'(bus_if.out_valid), 32'd1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!bus_if.flush_done && n < budget) begin
      cyc();
      n++;
    end
    chk(name, 32'(bus_if.flush_done), 32'd1);
  endtask

  task automatic pulse_write(input logic [9:0] b);
    bus_if.eeprom_blk     = b;
    bus_if.eeprom_written = 1'b1;
    cyc();
    bus_if.eeprom_written = 1'b0;
  endtask

  // Stream monitor: pops the scoreboard on every accepted byte.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus_if.flush_done) n_done++;
    if (!rst && bus_if.out_valid && bus_if.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_extra: unexpected byte 0x%0h blk %0d", bus_if.out_data, bus_if.out_blk);
      end else begin
        e = sb.pop_front();
        chk("stream_data", 32'(bus_if.out_data), 32'(e.data));
        chk("stream_blk", 32'(bus_if.out_blk), 32'(e.blk));
        chk("stream_last", 32'(bus_if.out_last), 32'(e.last));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 8; i++)
        hv[j*8+i] = '{rd: 1'b0, wr: 1'b1, addr: 13'(BLKS[j]*8 + i),
                      wdata: pat(BLKS[j], i), rdata: 8'h00};
    for (int i = 0; i < 8; i++)
      hv[32+i] = '{rd: 1'b1, wr: 1'b0, addr: 13'(BLKS[2+i/4]*8 + i),
                   wdata: 8'h00, rdata: pat(BLKS[2+i/4], i)};

    rst                   = 1'b1;
    bus_if.model          = 1'b1;
    bus_if.eeprom_written = 1'b0;
    bus_if.eeprom_blk     = '0;
    bus_if.flush_req      = 1'b0;
    bus_if.rv_rd          = 1'b0;
    bus_if.rv_wr          = 1'b0;
    bus_if.rv_addr        = '0;
    bus_if.rv_wdata       = '0;
    bus_if.out_ready      = 1'b1;
    repeat (3) cyc();

    chk("rst_busy", 32'(bus_if.busy), 0);
    chk("rst_out_valid", 32'(bus_if.out_valid), 0);
    chk("rst_out_last", 32'(bus_if.out_last), 0);
    chk("rst_out_data", 32'(bus_if.out_data), 0);
    chk("rst_out_blk", 32'(bus_if.out_blk), 0);
    chk("rst_flush_done", 32'(bus_if.flush_done), 0);
    chk("rst_dirty_any", 32'(bus_if.dirty_any), 0);
    chk("rst_mem_rd", 32'(bus_if.mem_rd), 0);
    chk("rst_mem_wr", 32'(bus_if.mem_wr), 0);
    rst = 1'b0;
    cyc();

    // Host port vectors: preload blocks, then read some back.
    for (int k = 0; k < 40; k++) begin
      bus_if.rv_rd    = hv[k].rd;
      bus_if.rv_wr    = hv[k].wr;
      bus_if.rv_addr  = hv[k].addr;
      bus_if.rv_wdata = hv[k].wdata;
      #1;
      chk("hv_mem_rd", 32'(bus_if.mem_rd), 32'(hv[k].rd));
      chk("hv_mem_wr", 32'(bus_if.mem_wr), 32'(hv[k].wr));
      chk("hv_mem_addr", 32'(bus_if.mem_addr), 32'(hv[k].addr));
      if (hv[k].wr) chk("hv_mem_wdata", 32'(bus_if.mem_wdata), 32'(hv[k].wdata));
      cyc();
      bus_if.rv_rd = 1'b0;
      bus_if.rv_wr = 1'b0;
      if (hv[k].rd) chk("hv_rv_rdata", 32'(bus_if.rv_rdata), 32'(hv[k].rdata));
    end
    chk("hv_no_dirty", 32'(bus_if.dirty_any), 0);

    // Block write and automatic flush of block 5.
    push_blk(5);
    pulse_write(10'd5);
    chk("s1_dirty_set", 32'(bus_if.dirty_any), 1);
    repeat (Q) cyc();
    chk("s1_busy_before_quiet", 32'(bus_if.busy), 0);
    cyc();
    chk("s1_busy_at_quiet", 32'(bus_if.busy), 1);
    repeat (7) cyc();
    chk("s1_valid_early", 32'(bus_if.out_valid), 0);
    cyc();
    chk("s1_first_valid", 32'(bus_if.out_valid), 1);
    chk("s1_first_blk", 32'(bus_if.out_blk), 5);
    d0 = n_done;
    wait_done("s1_done", 3000);
    cyc();
    cyc();
    chk("s1_done_pulses", 32'(n_done - d0), 1);
    chk("s1_dirty_clear", 32'(bus_if.dirty_any), 0);
    chk("s1_sb_empty", 32'(sb.size()), 0);
    chk("s1_idle", 32'(bus_if.busy), 0);

    // Repeated writes keep restarting the quiet timer.
    push_blk(2);
    for (int p = 0; p < 10; p++) begin
      pulse_write(10'd2);
      for (int c = 0; c < 9; c++) begin
        chk("s2_busy_quiet", 32'(bus_if.busy), 0);
        cyc();
      end
    end
    repeat (Q - 9) cyc();
    chk("s2_busy_before_quiet", 32'(bus_if.busy), 0);
    cyc();
    chk("s2_busy_at_quiet", 32'(bus_if.busy), 1);

    // Host reads contend with the flush of block 2.
    wait_valid("s3_valid", 100);
    for (int k = 0; k < 5; k++) begin
      bus_if.rv_rd   = 1'b1;
      bus_if.rv_addr = 13'(40 + k);
      #1;
      chk("s3_host_addr", 32'(bus_if.mem_addr), 32'(40 + k));
      cyc();
      chk("s3_host_rdata", 32'(bus_if.rv_rdata), 32'(pat(5, k)));
      chk("s3_stream_stalled", 32'(bus_if.out_valid), 0);
    end
    bus_if.rv_rd = 1'b0;
    wait_done("s3_done", 3000);
    cyc();
    chk("s3_sb_empty", 32'(sb.size()), 0);
    chk("s3_dirty_clear", 32'(bus_if.dirty_any), 0);

    // Backpressure on byte 3 of block 7 with a re-dirty during the stall.
    bus_if.out_ready = 1'b0;
    push_blk(7);
    pulse_write(10'd7);
    bus_if.flush_req = 1'b1;
    cyc();
    bus_if.flush_req = 1'b0;
    chk("s4_busy_on_req", 32'(bus_if.busy), 1);
    for (int b = 0; b < 3; b++) begin
      wait_valid("s4_valid", 50);
      bus_if.out_ready = 1'b1;
      cyc();
      bus_if.out_ready = 1'b0;
    end
    wait_valid("s4_valid_b3", 50);
    for (int s = 0; s < 20; s++) begin
      chk("s4_hold_valid", 32'(bus_if.out_valid), 1);
      chk("s4_hold_data", 32'(bus_if.out_data), 32'(pat(7, 3)));
      chk("s4_hold_blk", 32'(bus_if.out_blk), 7);
      chk("s4_hold_last", 32'(bus_if.out_last), 0);
      bus_if.eeprom_blk     = 10'd7;
      bus_if.eeprom_written = (s == 5);
      cyc();
    end
    bus_if.eeprom_written = 1'b0;
    bus_if.out_ready      = 1'b1;
    wait_done("s4_done", 3000);
    cyc();
    chk("s4_redirty", 32'(bus_if.dirty_any), 1);
    chk("s4_sb_empty", 32'(sb.size()), 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("s4_rst_dirty", 32'(bus_if.dirty_any), 0);

    // Small EEPROM: index masking and explicit flush request.
    bus_if.model = 1'b0;
    push_blk(5);
    push_blk(63);
    pulse_write(10'h3C5);
    pulse_write(10'd63);
    bus_if.flush_req = 1'b1;
    cyc();
    bus_if.flush_req = 1'b0;
    chk("s5_busy_on_req", 32'(bus_if.busy), 1);
    wait_done("s5_done", 500);
    cyc();
    chk("s5_sb_empty", 32'(sb.size()), 0);
    chk("s5_dirty_clear", 32'(bus_if.dirty_any), 0);

    // Reset in the middle of SEND.
    bus_if.model     = 1'b1;
    bus_if.out_ready = 1'b0;
    pulse_write(10'd2);
    bus_if.eeprom_blk     = 10'd9;
    bus_if.eeprom_written = 1'b1;
    bus_if.flush_req      = 1'b1;
    cyc();
    bus_if.eeprom_written = 1'b0;
    bus_if.flush_req      = 1'b0;
    wait_valid("s6_valid", 100);
    rst = 1'b1;
    cyc();
    chk("s6_out_valid", 32'(bus_if.out_valid), 0);
    chk("s6_busy", 32'(bus_if.busy), 0);
    chk("s6_dirty_any", 32'(bus_if.dirty_any), 0);
    chk("s6_out_data", 32'(bus_if.out_data), 0);
    rst = 1'b0;
    bus_if.out_ready = 1'b1;
    repeat (Q + 5) cyc();
    chk("s6_no_flush", 32'(bus_if.busy), 0);
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
